stack_pc: RTL and testbench

Microsequenced control unit (parte controllo) for the stack unit's operative part (PO). Accepts one stack command at a time over a req/ack handshake. Drives PO's alpha (mux/ALU select) and beta (register write-enable) lines state by state, and consumes PO status flags. Sits between the host command interface and PO; PO is unchanged.

---
 rtl/stack_pc.sv | 202 ++++++++++++++++++++
 tb/tb_stack_pc.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/stack_pc.sv
// Microsequenced control unit for the stack operative part (PO): one command per
// req/ack handshake, Moore-decoded alpha (select) and beta (write-enable) lines.
module stack_pc #(
  parameter int MAX_SCAN = 1024,
  parameter int SCAN_W   = 11
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       req,
  input  logic [2:0] op,
  output logic       ack,
  output logic       err,
  output logic       busy,
  input  logic       hd_full,
  input  logic       hd_empty,
  input  logic       match,
  input  logic       i_end,
  output logic       alpha_k1,
  output logic       alpha_k2,
  output logic       alpha_k3,
  output logic       alpha_k4,
  output logic       alpha_k5,
  output logic       alpha_k_ind,
  output logic       alpha_k_i,
  output logic       alpha_k_esito,
  output logic       alpha_k_dataout,
  output logic       alpha_k_mem1,
  output logic       alpha_k_mem2,
  output logic [2:0] alpha_alu2,
  output logic [2:0] alpha_alu3,
  output logic [2:0] alpha_alu4,
  output logic       beta_hd,
  output logic       beta_ind,
  output logic       beta_i,
  output logic       beta_esito,
  output logic       beta_datain,
  output logic       beta_dataout,
  output logic       beta_mem
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_LOAD     = 4'd1;
  localparam logic [3:0] S_PUSH_W   = 4'd2;
  localparam logic [3:0] S_PUSH_INC = 4'd3;
  localparam logic [3:0] S_POP_DEC  = 4'd4;
  localparam logic [3:0] S_POP_RD   = 4'd5;
  localparam logic [3:0] S_TOP_RD   = 4'd6;
  localparam logic [3:0] S_CLR      = 4'd7;
  localparam logic [3:0] S_S_INIT   = 4'd8;
  localparam logic [3:0] S_S_CMP    = 4'd9;
  localparam logic [3:0] S_S_NEXT   = 4'd10;
  localparam logic [3:0] S_S_HIT    = 4'd11;
  localparam logic [3:0] S_DONE     = 4'd12;
  localparam logic [3:0] S_ERR      = 4'd13;

  localparam logic [2:0] OP_NOP    = 3'd0;
  localparam logic [2:0] OP_PUSH   = 3'd1;
  localparam logic [2:0] OP_POP    = 3'd2;
  localparam logic [2:0] OP_TOP    = 3'd3;
  localparam logic [2:0] OP_CLEAR  = 3'd4;
  localparam logic [2:0] OP_SEARCH = 3'd5;

  localparam logic [2:0] ALU_INC  = 3'd1;
  localparam logic [2:0] ALU_DEC  = 3'd2;
  localparam logic [2:0] ALU_ZERO = 3'd3;

  localparam logic [SCAN_W-1:0] SCAN_LIMIT = SCAN_W'(MAX_SCAN);

  logic [3:0]        state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [SCAN_W-1:0] scan_q, scan_d;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      op_q    <= OP_NOP;
      scan_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      scan_q  <= scan_d;
    end
  end

  // Flags are only consulted in LOAD and S_CMP; every other state has a fixed successor.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    scan_d  = scan_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          op_d = op;
          if (op != OP_NOP) state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        case (op_q)
          OP_PUSH:   state_d = hd_full  ? S_ERR : S_PUSH_W;
          OP_POP:    state_d = hd_empty ? S_ERR : S_POP_DEC;
          OP_TOP:    state_d = hd_empty ? S_ERR : S_TOP_RD;
          OP_CLEAR:  state_d = S_CLR;
          OP_SEARCH: state_d = S_S_INIT;
          default:   state_d = S_ERR;
        endcase
      end
      S_PUSH_W:   state_d = S_PUSH_INC;
      S_PUSH_INC: state_d = S_DONE;
      S_POP_DEC:  state_d = S_POP_RD;
      S_POP_RD:   state_d = S_DONE;
      S_TOP_RD:   state_d = S_DONE;
      S_CLR:      state_d = S_DONE;
      S_S_INIT: begin
        scan_d  = '0;
        state_d = S_S_CMP;
      end
      S_S_CMP: begin
        if (i_end)                     state_d = S_DONE;
        else if (match)                state_d = S_S_HIT;
        else if (scan_q == SCAN_LIMIT) state_d = S_ERR;
        else                           state_d = S_S_NEXT;
      end
      S_S_NEXT: begin
        scan_d  = scan_q + SCAN_W'(1);
        state_d = S_S_CMP;
      end
      S_S_HIT: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Zero-valued selects (k_i, k_dataout, k_mem1 = 0) are the defaults below.
  always_comb begin
    ack             = 1'b0;
    err             = 1'b0;
    busy            = (state_q != S_IDLE);
    alpha_k1        = 1'b0;
    alpha_k2        = 1'b0;
    alpha_k3        = 1'b0;
    alpha_k4        = 1'b0;
    alpha_k5        = 1'b0;
    alpha_k_ind     = 1'b0;
    alpha_k_i       = 1'b0;
    alpha_k_esito   = 1'b0;
    alpha_k_dataout = 1'b0;
    alpha_k_mem1    = 1'b0;
    alpha_k_mem2    = 1'b0;
    alpha_alu2      = 3'd0;
    alpha_alu3      = 3'd0;
    alpha_alu4      = 3'd0;
    beta_hd         = 1'b0;
    beta_ind        = 1'b0;
    beta_i          = 1'b0;
    beta_esito      = 1'b0;
    beta_datain     = 1'b0;
    beta_dataout    = 1'b0;
    beta_mem        = 1'b0;
    case (state_q)
      S_LOAD:     beta_datain = 1'b1;
      S_PUSH_W:   beta_mem = 1'b1;
      S_PUSH_INC: begin
        alpha_alu2 = ALU_INC;
        beta_hd    = 1'b1;
      end
      S_POP_DEC: begin
        alpha_alu2 = ALU_DEC;
        beta_hd    = 1'b1;
      end
      S_POP_RD:   beta_dataout = 1'b1;
      S_TOP_RD: begin
        alpha_k_mem2 = 1'b1;
        beta_dataout = 1'b1;
      end
      S_CLR: begin
        alpha_alu2 = ALU_ZERO;
        beta_hd    = 1'b1;
      end
      S_S_INIT: begin
        alpha_alu3 = ALU_ZERO;
        beta_i     = 1'b1;
        beta_esito = 1'b1;
      end
      S_S_NEXT: begin
        alpha_alu3 = ALU_INC;
        beta_i     = 1'b1;
      end
      S_S_HIT: begin
        alpha_k_esito = 1'b1;
        beta_esito    = 1'b1;
      end
      S_DONE: ack = 1'b1;
      S_ERR: begin
        ack = 1'b1;
        err = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_stack_pc.sv
// Directed bench for stack_pc: walks each command through its state sequence and
// compares every control output against the per-state values expected from the design intent.
module tb_stack_pc;

  logic       clock;
  logic       reset_n;
  logic       req;
  logic [2:0] op;
  logic       hd_full, hd_empty, match, i_end;
  logic       ack, err, busy;
  logic       alpha_k1, alpha_k2, alpha_k3, alpha_k4, alpha_k5, alpha_k_ind;
  logic       alpha_k_i, alpha_k_esito, alpha_k_dataout, alpha_k_mem1, alpha_k_mem2;
  logic [2:0] alpha_alu2, alpha_alu3, alpha_alu4;
  logic       beta_hd, beta_ind, beta_i, beta_esito, beta_datain, beta_dataout, beta_mem;

  int errCount;
  int checkCount;

  stack_pc #(.MAX_SCAN(4), .SCAN_W(11)) dut (
    .clock(clock), .reset_n(reset_n), .req(req), .op(op),
    .ack(ack), .err(err), .busy(busy),
    .hd_full(hd_full), .hd_empty(hd_empty), .match(match), .i_end(i_end),
    .alpha_k1(alpha_k1), .alpha_k2(alpha_k2), .alpha_k3(alpha_k3),
    .alpha_k4(alpha_k4), .alpha_k5(alpha_k5), .alpha_k_ind(alpha_k_ind),
    .alpha_k_i(alpha_k_i), .alpha_k_esito(alpha_k_esito),
    .alpha_k_dataout(alpha_k_dataout), .alpha_k_mem1(alpha_k_mem1),
    .alpha_k_mem2(alpha_k_mem2),
    .alpha_alu2(alpha_alu2), .alpha_alu3(alpha_alu3), .alpha_alu4(alpha_alu4),
    .beta_hd(beta_hd), .beta_ind(beta_ind), .beta_i(beta_i),
    .beta_esito(beta_esito), .beta_datain(beta_datain),
    .beta_dataout(beta_dataout), .beta_mem(beta_mem)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Packed view of every output; bit positions match the B_* masks below.
  logic [29:0] obsVec;
  assign obsVec = {ack, err, busy,
                   beta_hd, beta_ind, beta_i, beta_esito, beta_datain, beta_dataout, beta_mem,
                   alpha_k_i, alpha_k_esito, alpha_k_dataout, alpha_k_mem1, alpha_k_mem2,
                   alpha_alu2, alpha_alu3, alpha_alu4,
                   alpha_k1, alpha_k2, alpha_k3, alpha_k4, alpha_k5, alpha_k_ind};

  localparam logic [29:0] B_ACK   = 30'd1 << 29;
  localparam logic [29:0] B_ERR   = 30'd1 << 28;
  localparam logic [29:0] B_BUSY  = 30'd1 << 27;
  localparam logic [29:0] B_HD    = 30'd1 << 26;
  localparam logic [29:0] B_BI    = 30'd1 << 24;
  localparam logic [29:0] B_BES   = 30'd1 << 23;
  localparam logic [29:0] B_DIN   = 30'd1 << 22;
  localparam logic [29:0] B_DOUT  = 30'd1 << 21;
  localparam logic [29:0] B_MEM   = 30'd1 << 20;
  localparam logic [29:0] B_KES   = 30'd1 << 18;
  localparam logic [29:0] B_KMEM2 = 30'd1 << 15;
  localparam logic [29:0] A2_INC  = 30'd1 << 12;
  localparam logic [29:0] A2_DEC  = 30'd2 << 12;
  localparam logic [29:0] A2_ZERO = 30'd3 << 12;
  localparam logic [29:0] A3_INC  = 30'd1 << 9;
  localparam logic [29:0] A3_ZERO = 30'd3 << 9;

  localparam logic [29:0] E_IDLE    = 30'd0;
  localparam logic [29:0] E_LOAD    = B_BUSY | B_DIN;
  localparam logic [29:0] E_PUSHW   = B_BUSY | B_MEM;
  localparam logic [29:0] E_PUSHINC = B_BUSY | B_HD | A2_INC;
  localparam logic [29:0] E_POPDEC  = B_BUSY | B_HD | A2_DEC;
  localparam logic [29:0] E_POPRD   = B_BUSY | B_DOUT;
  localparam logic [29:0] E_TOPRD   = B_BUSY | B_KMEM2 | B_DOUT;
  localparam logic [29:0] E_CLR     = B_BUSY | B_HD | A2_ZERO;
  localparam logic [29:0] E_SINIT   = B_BUSY | B_BI | A3_ZERO | B_BES;
  localparam logic [29:0] E_SCMP    = B_BUSY;
  localparam logic [29:0] E_SNEXT   = B_BUSY | B_BI | A3_INC;
  localparam logic [29:0] E_SHIT    = B_BUSY | B_KES | B_BES;
  localparam logic [29:0] E_DONE    = B_ACK | B_BUSY;
  localparam logic [29:0] E_ERR     = B_ACK | B_ERR | B_BUSY;

  task automatic applyStimulus(input logic r, input logic [2:0] o,
                               input logic full, input logic empty,
                               input logic m, input logic iend);
    req      = r;
    op       = o;
    hd_full  = full;
    hd_empty = empty;
    match    = m;
    i_end    = iend;
  endtask

  task automatic checkOutput(input string tag, input logic [29:0] expected);
    checkCount++;
    assert (obsVec === expected)
    else begin
      errCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obsVec, expected);
    end
  endtask

  // Advance one edge, then sample on the falling edge.
  task automatic stepCheck(input string tag, input logic [29:0] expected);
    @(posedge clock);
    @(negedge clock);
    checkOutput(tag, expected);
  endtask

  initial begin
    errCount   = 0;
    checkCount = 0;
    reset_n    = 1'b0;
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clock);
    stepCheck("reset_idle", E_IDLE);
    reset_n = 1'b1;
    stepCheck("idle_after_reset", E_IDLE);

    $display("[TB] PUSH into empty stack");
    applyStimulus(1'b1, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0);
    stepCheck("push_load", E_LOAD);
    req = 1'b0;
    stepCheck("push_w", E_PUSHW);
    stepCheck("push_inc", E_PUSHINC);
    stepCheck("push_done", E_DONE);
    stepCheck("push_idle", E_IDLE);

    $display("[TB] NOP request is ignored");
    applyStimulus(1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    stepCheck("nop_idle", E_IDLE);
    req = 1'b0;

    $display("[TB] POP on empty stack");
    applyStimulus(1'b1, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    stepCheck("pop_empty_load", E_LOAD);
    req = 1'b0;
    stepCheck("pop_empty_err", E_ERR);
    stepCheck("pop_empty_idle", E_IDLE);

    $display("[TB] PUSH on full stack");
    applyStimulus(1'b1, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    stepCheck("push_full_load", E_LOAD);
    req = 1'b0;
    stepCheck("push_full_err", E_ERR);
    stepCheck("push_full_idle", E_IDLE);

    $display("[TB] illegal opcode");
    applyStimulus(1'b1, 3'd6, 1'b0, 1'b0, 1'b0, 1'b0);
    stepCheck("illegal_load", E_LOAD);
    req = 1'b0;
    stepCheck("illegal_err", E_ERR);

    $display("[TB] POP on non-empty stack");
    applyStimulus(1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    stepCheck("pop_idle_gap", E_IDLE);
    stepCheck("pop_load", E_LOAD);
    req = 1'b0;
    stepCheck("pop_dec", E_POPDEC);
    stepCheck("pop_rd", E_POPRD);
    stepCheck("pop_done", E_DONE);
    stepCheck("pop_idle", E_IDLE);

    $display("[TB] CLEAR with req and op changing while busy");
    applyStimulus(1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0);
    stepCheck("clr_load", E_LOAD);
    op = 3'd2;
    stepCheck("clr_clr", E_CLR);
    req = 1'b0;
    stepCheck("clr_done", E_DONE);
    stepCheck("clr_idle", E_IDLE);

    $display("[TB] SEARCH hit on third compare");
    applyStimulus(1'b1, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    stepCheck("sh_load", E_LOAD);
    req = 1'b0;
    stepCheck("sh_init", E_SINIT);
    stepCheck("sh_cmp1", E_SCMP);
    stepCheck("sh_next1", E_SNEXT);
    stepCheck("sh_cmp2", E_SCMP);
    stepCheck("sh_next2", E_SNEXT);
    stepCheck("sh_cmp3", E_SCMP);
    match = 1'b1;
    stepCheck("sh_hit", E_SHIT);
    match = 1'b0;
    stepCheck("sh_done", E_DONE);
    stepCheck("sh_idle", E_IDLE);

    $display("[TB] SEARCH with i_end on first compare, i_end beats match");
    applyStimulus(1'b1, 3'd5, 1'b0, 1'b0, 1'b1, 1'b1);
    stepCheck("se_load", E_LOAD);
    req = 1'b0;
    stepCheck("se_init", E_SINIT);
    stepCheck("se_cmp", E_SCMP);
    stepCheck("se_done", E_DONE);
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    stepCheck("se_idle", E_IDLE);

    $display("[TB] SEARCH scan timeout");
    applyStimulus(1'b1, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    stepCheck("st_load", E_LOAD);
    req = 1'b0;
    stepCheck("st_init", E_SINIT);
    for (int k = 0; k < 4; k++) begin
      stepCheck($sformatf("st_cmp%0d", k), E_SCMP);
      stepCheck($sformatf("st_next%0d", k), E_SNEXT);
    end
    stepCheck("st_cmp_last", E_SCMP);
    stepCheck("st_err", E_ERR);
    stepCheck("st_idle", E_IDLE);

    $display("[TB] reset during POP_DEC, then TOP");
    applyStimulus(1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    stepCheck("rp_load", E_LOAD);
    req = 1'b0;
    stepCheck("rp_dec", E_POPDEC);
    reset_n = 1'b0;
    stepCheck("rp_reset_idle", E_IDLE);
    reset_n = 1'b1;
    stepCheck("rp_no_ack", E_IDLE);
    applyStimulus(1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    stepCheck("top_load", E_LOAD);
    req = 1'b0;
    stepCheck("top_rd", E_TOPRD);
    stepCheck("top_done", E_DONE);
    applyStimulus(1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0);
    stepCheck("b2b_idle", E_IDLE);
    stepCheck("b2b_load", E_LOAD);
    req = 1'b0;
    stepCheck("b2b_clr", E_CLR);
    stepCheck("b2b_done", E_DONE);
    stepCheck("b2b_idle_end", E_IDLE);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
